// File: rtl/pwr_buf_pkg.sv
// Shared types for the power-gated buffer bank: sequencer state encoding,
// the registered control bundle it drives, and the counter width helper.
package pwr_buf_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_PWRUP   = 3'd1,
        ST_RESTORE = 3'd2,
        ST_ON      = 3'd3,
        ST_SAVE    = 3'd4,
        ST_PWRDN   = 3'd5
    } pwr_state_e;

    typedef struct packed {
        logic pwr_en;
        logic iso;
        logic ret_save;
        logic ack;
        logic restore;
        logic clr;
    } seq_out_t;

    function automatic int cnt_width(input int up_cyc, input int dn_cyc);
        int m;
        m = (up_cyc > dn_cyc) ? up_cyc : dn_cyc;
        return $clog2(m + 1);
    endfunction

    // Control levels that hold for the whole time the sequencer sits in a state.
    function automatic seq_out_t seq_outs(input pwr_state_e s);
        seq_out_t o;
        o = '{pwr_en: 1'b0, iso: 1'b1, ret_save: 1'b0, ack: 1'b0,
              restore: 1'b0, clr: 1'b0};
        case (s)
            ST_PWRUP:   o.pwr_en = 1'b1;
            ST_RESTORE: begin o.pwr_en = 1'b1; o.restore = 1'b1; end
            ST_ON:      begin o.pwr_en = 1'b1; o.iso = 1'b0; o.ack = 1'b1; end
            ST_SAVE:    begin o.pwr_en = 1'b1; o.ret_save = 1'b1; o.clr = 1'b1; end
            default:    o.pwr_en = 1'b0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pwr_seq_fsm.sv
// Power sequencer for the gated buffer island: rail switch, isolation clamp
// and retention save/restore, with a shared down-counter for settle delays.
//
//   state   | meaning
//   OFF     | rail off, outputs clamped, waiting for pwr_req
//   PWRUP   | rail switched on, counting PWRUP_CYC settle cycles
//   RESTORE | one cycle: main registers reload from retention
//   ON      | domain live, isolation released, ack high
//   SAVE    | one cycle: retention captures main, clamp re-applied
//   PWRDN   | rail off, main state lost, counting PWRDN_CYC cycles
module pwr_seq_fsm
    import pwr_buf_pkg::*;
#(
    parameter int PWRUP_CYC = 8,
    parameter int PWRDN_CYC = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pwr_req_i,
    output pwr_state_e state_o,
    output seq_out_t   outs_o
);

    localparam int CW = cnt_width(PWRUP_CYC, PWRDN_CYC);

    pwr_state_e    state;
    seq_out_t      outs;
    logic [CW-1:0] cnt;

    // Outputs are loaded together with the next state, so they are true flops
    // that change on the same edge as state_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_OFF;
            outs  <= seq_outs(ST_OFF);
            cnt   <= '0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (pwr_req_i) begin
                        state <= ST_PWRUP;
                        outs  <= seq_outs(ST_PWRUP);
                        cnt   <= CW'(PWRUP_CYC - 1);
                    end
                end
                ST_PWRUP: begin
                    if (cnt == '0) begin
                        state <= ST_RESTORE;
                        outs  <= seq_outs(ST_RESTORE);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESTORE: begin
                    state <= ST_ON;
                    outs  <= seq_outs(ST_ON);
                end
                ST_ON: begin
                    if (!pwr_req_i) begin
                        state <= ST_SAVE;
                        outs  <= seq_outs(ST_SAVE);
                    end
                end
                ST_SAVE: begin
                    state <= ST_PWRDN;
                    outs  <= seq_outs(ST_PWRDN);
                    cnt   <= CW'(PWRDN_CYC - 1);
                end
                ST_PWRDN: begin
                    if (cnt == '0) begin
                        state <= ST_OFF;
                        outs  <= seq_outs(ST_OFF);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_OFF;
                    outs  <= seq_outs(ST_OFF);
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign state_o = state;
    assign outs_o  = outs;

endmodule

// File: rtl/pwr_gated_buf_bank.sv
// NCH registered buffer channels inside a switchable power domain, each with a
// retention shadow, driven by the on-chip power sequencer.
module pwr_gated_buf_bank
    import pwr_buf_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int WIDTH     = 16,
    parameter int PWRUP_CYC = 8,
    parameter int PWRDN_CYC = 4,
    parameter bit CLAMP_VAL = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pwr_req_i,
    output logic                 pwr_ack_o,
    output logic                 pwr_en_o,
    output logic                 iso_o,
    output logic                 ret_save_o,
    input  logic [NCH-1:0]       valid_i,
    input  logic [NCH*WIDTH-1:0] data_i,
    output logic [NCH-1:0]       valid_o,
    output logic [NCH*WIDTH-1:0] data_o,
    output logic [2:0]           state_o
);

    pwr_state_e           state;
    seq_out_t             seq;
    logic [NCH-1:0]       valid_q;
    logic [NCH*WIDTH-1:0] main_flat;

    pwr_seq_fsm #(
        .PWRUP_CYC (PWRUP_CYC),
        .PWRDN_CYC (PWRDN_CYC)
    ) u_seq (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .pwr_req_i (pwr_req_i),
        .state_o   (state),
        .outs_o    (seq)
    );

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [WIDTH-1:0] main_q;
        logic [WIDTH-1:0] ret_q;

        // Restore, clear and capture are mutually exclusive by state.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                main_q <= '0;
                ret_q  <= '0;
            end else begin
                if (seq.restore)
                    main_q <= ret_q;
                else if (seq.clr)
                    main_q <= '0;
                else if (seq.ack && valid_i[c])
                    main_q <= data_i[c*WIDTH +: WIDTH];
                if (seq.ret_save)
                    ret_q <= main_q;
            end
        end

        assign main_flat[c*WIDTH +: WIDTH] = main_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            valid_q <= '0;
        else
            valid_q <= seq.ack ? valid_i : '0;
    end

    // Gate valid with the clamp so the last ON-cycle valid never leaks into SAVE.
    assign valid_o    = seq.iso ? '0 : valid_q;
    assign data_o     = seq.iso ? {(NCH*WIDTH){CLAMP_VAL}} : main_flat;
    assign pwr_ack_o  = seq.ack;
    assign pwr_en_o   = seq.pwr_en;
    assign iso_o      = seq.iso;
    assign ret_save_o = seq.ret_save;
    assign state_o    = state;

endmodule

// File: tb/tb_pwr_gated_buf_bank.sv
// Directed bench for the power-gated buffer bank: default bank plus a small
// CLAMP_VAL=1 instance sharing clock, reset and power request.
module tb_pwr_gated_buf_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [3:0]  v;
    logic [63:0] d;
    logic        ack, en, iso, save;
    logic [3:0]  vo;
    logic [63:0] dout;
    logic [2:0]  st;

    logic [1:0]  v2;
    logic [15:0] d2;
    logic        ack2, en2, iso2, save2;
    logic [1:0]  vo2;
    logic [15:0] dout2;
    logic [2:0]  st2;

    int n_chk  = 0;
    int n_fail = 0;
    int n_save = 0;
    int n_on   = 0;

    typedef struct {
        logic [3:0]  v;
        logic [63:0] d;
        logic [3:0]  ev;
        logic [63:0] ed;
    } vec_t;
    vec_t tbl [4];

    always #5 clk = ~clk;

    pwr_gated_buf_bank dut (
        .clk_i(clk), .rst_i(rst), .pwr_req_i(req), .pwr_ack_o(ack),
        .pwr_en_o(en), .iso_o(iso), .ret_save_o(save), .valid_i(v),
        .data_i(d), .valid_o(vo), .data_o(dout), .state_o(st)
    );

    pwr_gated_buf_bank #(.NCH(2), .WIDTH(8), .CLAMP_VAL(1'b1)) dut2 (
        .clk_i(clk), .rst_i(rst), .pwr_req_i(req), .pwr_ack_o(ack2),
        .pwr_en_o(en2), .iso_o(iso2), .ret_save_o(save2), .valid_i(v2),
        .data_i(d2), .valid_o(vo2), .data_o(dout2), .state_o(st2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_st(input string name, input logic [2:0] e_st, input logic e_en,
                          input logic e_iso, input logic e_ack, input logic e_save);
        chk({name, ".state"}, 64'(st), 64'(e_st));
        chk({name, ".pwr_en"}, 64'(en), 64'(e_en));
        chk({name, ".iso"}, 64'(iso), 64'(e_iso));
        chk({name, ".ack"}, 64'(ack), 64'(e_ack));
        chk({name, ".ret_save"}, 64'(save), 64'(e_save));
    endtask

    initial begin
        tbl[0] = '{4'b0101, {16'h2222, 16'h1234, 16'h1111, 16'hA5A5},
                   4'b0101, {16'h0000, 16'h1234, 16'h0000, 16'hA5A5}};
        tbl[1] = '{4'b0000, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                   4'b0000, {16'h0000, 16'h1234, 16'h0000, 16'hA5A5}};
        tbl[2] = '{4'b1010, {16'hCAFE, 16'h7777, 16'hBEEF, 16'h7777},
                   4'b1010, {16'hCAFE, 16'h1234, 16'hBEEF, 16'hA5A5}};
        tbl[3] = '{4'b1010, 64'h0,
                   4'b1010, {16'h0000, 16'h1234, 16'h0000, 16'hA5A5}};

        rst = 1'b1; req = 1'b0; v = '0; d = '0; v2 = '0; d2 = '0;
        tick(); tick();
        rst = 1'b0;
        chk_st("reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("reset.valid", 64'(vo), 64'h0);
        chk("reset.data", dout, 64'h0);
        chk("reset.clamp1", 64'(dout2), 64'hFFFF);

        // Power-up latency: PWRUP cycles 1..8, RESTORE 9, ON 10.
        req = 1'b1;
        tick();
        chk_st("pwrup_c1", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("pwrup.clamp1", 64'(dout2), 64'hFFFF);
        repeat (7) tick();
        chk_st("pwrup_c8", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_st("restore_c9", 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_st("on_c10", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("on_c10.data", dout, 64'h0);
        chk("on_c10.data2", 64'(dout2), 64'h0);
        chk("on_c10.valid", 64'(vo), 64'h0);

        v2 = 2'b11; d2 = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            v = tbl[i].v; d = tbl[i].d;
            tick();
            chk($sformatf("vec%0d.valid", i), 64'(vo), 64'(tbl[i].ev));
            chk($sformatf("vec%0d.data", i), dout, tbl[i].ed);
        end
        v = '0; d = '0; v2 = '0; d2 = '0;
        chk("on.data2_written", 64'(dout2), 64'hFFFF);

        // Power-down then restore of the captured channels.
        req = 1'b0;
        tick();
        chk_st("save", 3'd4, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("save.data", dout, 64'h0);
        chk("save.valid", 64'(vo), 64'h0);
        tick();
        chk_st("pwrdn_c1", 3'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("pwrdn.clamp1", 64'(dout2), 64'hFFFF);
        repeat (3) tick();
        chk_st("pwrdn_c4", 3'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_st("off_after_dn", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        req = 1'b1;
        repeat (10) tick();
        chk_st("on_again", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("on_again.data", dout, {16'h0000, 16'h1234, 16'h0000, 16'hA5A5});
        chk("on_again.data2", 64'(dout2), 64'hFFFF);

        // One-cycle request pulse: full sequence, one ON cycle, one save.
        req = 1'b0;
        repeat (6) tick();
        chk("pulse.start_off", 64'(st), 64'd0);
        req = 1'b1;
        tick();
        req = 1'b0;
        n_save = 0; n_on = 0;
        repeat (8) begin
            tick();
            n_save += int'(save); n_on += int'(ack);
        end
        chk("pulse.restore", 64'(st), 64'd2);
        tick();
        n_save += int'(save); n_on += int'(ack);
        chk_st("pulse_on", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("pulse_on.data", dout, {16'h0000, 16'h1234, 16'h0000, 16'hA5A5});
        tick();
        n_save += int'(save); n_on += int'(ack);
        chk("pulse.save", 64'(st), 64'd4);
        repeat (5) begin
            tick();
            n_save += int'(save); n_on += int'(ack);
        end
        chk("pulse.end_off", 64'(st), 64'd0);
        chk("pulse.on_cycles", 64'(n_on), 64'd1);
        chk("pulse.save_pulses", 64'(n_save), 64'd1);

        // Reset mid-PWRUP clears retention, later RESTORE gives zeros.
        req = 1'b1;
        repeat (5) tick();
        chk("abort.in_pwrup", 64'(st), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_st("rst_abort", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (10) tick();
        chk_st("after_abort_on", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("after_abort.data", dout, 64'h0);
        chk("after_abort.data2", 64'(dout2), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pwr_gated_buf_bank.md
Name: pwr_gated_buf_bank

Overview:
- Parametrised, power-aware successor to the single-bit X16 buffer cells: NCH channels of WIDTH-bit registered buffers inside a switchable power domain.
- Contains an on-chip power sequencer FSM that drives the switch enable, the isolation clamp and the retention save/restore. Outputs are clamped while the domain is not fully on.
- Sits between an always-on controller and a gated accelerator island in the cluster.

Parameters:
NCH, 4, number of buffer channels
WIDTH, 16, bits per channel
PWRUP_CYC, 8, cycles spent in PWRUP waiting for the rail to settle (>=1)
PWRDN_CYC, 4, cycles spent in PWRDN before reporting off (>=1)
CLAMP_VAL, 0, 1-bit value replicated onto every data_o bit while isolated

Ports:
clk_i  in  1  clock, single domain
rst_i  in  1  reset, synchronous, active-high
pwr_req_i  in  1  1 = request domain on, 0 = request off
pwr_ack_o  out  1  1 only in state ON
pwr_en_o  out  1  power-switch enable to the gated rail
iso_o  out  1  isolation active
ret_save_o  out  1  retention save strobe (1 cycle)
valid_i  in  NCH  per-channel input valid
data_i  in  NCH*WIDTH  channel c at bits [c*WIDTH +: WIDTH]
valid_o  out  NCH  registered valid
data_o  out  NCH*WIDTH  registered data, clamped when iso_o=1
state_o  out  3  FSM state encoding, for debug

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - State goes to OFF.
  - pwr_en_o=0, iso_o=1, pwr_ack_o=0, ret_save_o=0, valid_o=0.
  - Main and retention registers are cleared to 0; data_o shows the clamp value.
  - Reset mid-sequence aborts the sequence immediately, from any state.
- FSM, one transition per clock edge:
  - OFF: pwr_en=0, iso=1. If pwr_req_i=1, go to PWRUP and load the counter with PWRUP_CYC-1.
  - PWRUP: pwr_en=1, iso=1. Counter decrements each cycle; at 0 go to RESTORE. Exactly PWRUP_CYC cycles in PWRUP.
  - RESTORE: pwr_en=1, iso=1, one cycle. Main registers load from the retention registers; go to ON.
  - ON: pwr_en=1, iso=0, ack=1. If pwr_req_i=0, go to SAVE.
  - SAVE: iso=1, ret_save_o=1, one cycle. Retention registers capture the main registers; go to PWRDN and load the counter with PWRDN_CYC-1.
  - PWRDN: pwr_en=0, iso=1. Main registers are cleared to 0 on entry (models the lost state). Counter at 0 goes to OFF.
- pwr_req_i is sampled only in OFF and ON. Changes during transitional states are ignored until the sequence completes: a drop during PWRUP still reaches ON, then powers down next cycle if still 0.
- Datapath, ON state only:
  - Per channel c, if valid_i[c]=1 the main register captures its slice; otherwise it holds.
  - valid_o[c] is valid_i[c] registered, giving 1-cycle latency.
  - In all other states valid_o=0 and input captures are blocked.
- data_o = iso_o ? {NCH*WIDTH{CLAMP_VAL}} : main registers.
  - iso_o is the registered state decode, so clamp and ack change on the same edge as the state.
- The retention contents persist across OFF. The first RESTORE after reset restores zeros.
- state_o encoding: OFF=0, PWRUP=1, RESTORE=2, ON=3, SAVE=4, PWRDN=5. Values 6 and 7 are illegal and recover to OFF on the next edge.

Decomposition:
- Package pwr_buf_pkg holds:
  - the state enum (3-bit) with the encodings above;
  - a function computing the counter width as clog2(max(PWRUP_CYC, PWRDN_CYC)+1).
- One sub-module, pwr_seq_fsm: FSM plus counter, producing pwr_en/iso/ret_save/ack/restore/clear strobes.
- The top module instantiates it and generates NCH channel register pairs (main and retention).

Test Plan:
1. Reset, then pwr_req_i=1 at cycle 0 -> pwr_en_o=1 at cycle 1; ON and pwr_ack_o=1 at cycle 1+8+1=10 (defaults); iso_o falls at cycle 10.
2. In ON, drive valid_i=4'b0101, ch0=16'hA5A5, ch2=16'h1234 -> next cycle valid_o=4'b0101 and data_o shows ch0=A5A5, ch2=1234; ch1 and ch3 hold 0.
3. From ON, drop pwr_req_i -> ret_save_o pulses once, data_o=0 (clamp) from the same edge, OFF after 1+4 cycles. Re-request -> after RESTORE, ch0=A5A5 and ch2=1234 are back.
4. Pulse pwr_req_i=1 for one cycle, then hold 0 -> the full PWRUP completes, ON for exactly 1 cycle, then SAVE/PWRDN to OFF.
5. Assert rst_i at PWRUP count 3 -> the next edge gives OFF, pwr_en_o=0, iso_o=1; retention registers are 0, so a later RESTORE yields all-zero data.
6. CLAMP_VAL=1, NCH=2, WIDTH=8 -> data_o=16'hFFFF in OFF, PWRUP and PWRDN, and also in ON once captured values are written back.
